btn_charge: RTL and testbench
=============================

Name: btn_charge

Overview:
- Upstream stage of the game `fsm`. Replaces the constant `btn` tie-off.
- Takes the raw pushbutton on the 50 MHz master clock, synchronises and debounces it, then measures press duration in render ticks.
- Hands the game FSM a single jump-power word through a valid/ready handshake.
- Also exposes live charge level so the renderer can draw a power bar while the button is held.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable master-clock cycles required before a level change is accepted (10 ms at 50 MHz).
- CHARGE_W, 8, width of the power/charge counter.
- CHARGE_MAX, 200, saturation value of the charge counter; must be < 2**CHARGE_W.
- CHARGE_MIN, 4, presses shorter than this many ticks are discarded as taps.

Ports:
- clk  in  1  master clock, 50 MHz
- clr  in  1  asynchronous, active-low reset
- btn_raw  in  1  raw pushbutton, asynchronous to clk, active-high
- rtick  in  1  one-clk-wide pulse per render frame, generated from rclk edge detect outside this block
- jump_ready  in  1  fsm can accept a jump (player idle on a square)
- jump_valid  out  1  power word available
- jump_power  out  CHARGE_W  charge accumulated during the press
- charging  out  1  high while a counted press is in progress
- charge_level  out  CHARGE_W  live counter value for the power bar

Behaviour:
- Reset (clr low, asynchronous) clears all outputs to 0, the synchroniser to 0 and the debounce counter to 0; FSM state goes to IDLE. Release of reset is synchronous to clk.
- Synchroniser: 2-flop chain on btn_raw, giving btn_s. Debounce: counter clears whenever btn_s equals btn_db; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, btn_db <= btn_s and the counter clears. Latency from a stable raw edge to btn_db is 2 + DEBOUNCE_CYCLES clk.
- rise/fall are 1-cycle pulses from btn_db edge detection.
- State machine:
  - IDLE: charge_level = 0, charging = 0.
    - rise with jump_ready = 1 goes to CHARGE.
    - rise with jump_ready = 0 goes to LOCKOUT. A press made mid-flight is ignored until released.
  - CHARGE: charging = 1.
    - Each rtick increments charge_level, saturating at CHARGE_MAX. No wrap.
    - On fall: if charge_level >= CHARGE_MIN, latch jump_power <= charge_level, assert jump_valid, go to OFFER. Otherwise go to IDLE with no output.
    - rtick and fall in the same cycle: the increment applies first and the latched value includes it.
  - OFFER: jump_valid = 1 and jump_power held stable until jump_valid & jump_ready. In that cycle jump_valid drops next clk and the state goes to IDLE. A rise while in OFFER is ignored; it does not start a new charge.
  - LOCKOUT: wait for fall, then go to IDLE.
- charge_level resets to 0 on leaving CHARGE. jump_power holds its last value after the handshake.
- Reset asserted mid-CHARGE or mid-OFFER discards the pending power. No jump_valid appears after reset release.

Optional Feature:
- Macro BTN_CHARGE_AUTO_RELEASE_EN.
- When defined: in CHARGE, reaching CHARGE_MAX behaves exactly like a fall at that tick (latch, go to OFFER). The FSM then waits for fall in LOCKOUT-equivalent handling before accepting a new rise, so holding does not re-trigger.
- When undefined: the counter stays saturated at CHARGE_MAX until the real release.

Decomposition:
- Shared consts package (alongside PX_WIDTH/SQ_WIDTH):
  - CHARGE_W and CHARGE_MAX, so the fsm and renderer size their ports identically.
  - State encodings IDLE=2'd0, CHARGE=2'd1, OFFER=2'd2, LOCKOUT=2'd3.
- One sub-module, btn_debounce: synchroniser, debounce counter, rise/fall pulse generation, parameterised by DEBOUNCE_CYCLES.
- Charge FSM and handshake stay in btn_charge.

Test Plan:
- Use DEBOUNCE_CYCLES=8 in sim.
- Bounce: toggle btn_raw 5 times at 3-clk spacing, then hold high → btn_db rises exactly 10 clk after the last toggle; only one rise pulse.
- Normal jump: jump_ready=1, hold for 37 rticks, release → jump_valid=1, jump_power=37. Hold jump_ready=0 for 20 clk → power is stable. Raise jump_ready → jump_valid=0 the next clk.
- Tap: hold for 3 rticks → no jump_valid; state returns to IDLE.
- Saturation: hold for 300 rticks → charge_level stops at 200; jump_power=200. With BTN_CHARGE_AUTO_RELEASE_EN, jump_valid=1 on the 200th rtick with the button still held, and no second offer before release.
- Busy lockout: press with jump_ready=0, then raise jump_ready mid-press, release → no charging and no jump_valid.
- Reset mid-CHARGE at charge_level=50: pull clr low for 3 clk → all outputs 0 immediately; after release with the button still high, no charge until a fresh rise.

Source files
------------

// File: rtl/btn_charge_pkg.sv
// Shared constants and charge FSM state encodings for the jump-power path.
// Lets the game fsm and renderer size their ports identically.
package btn_charge_pkg;

    localparam int CHARGE_W   = 8;
    localparam int CHARGE_MAX = 200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        OFFER   = 2'd2,
        LOCKOUT = 2'd3
    } charge_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchroniser, debounce counter and registered rise/fall pulses.
// rise/fall assert in the same cycle that btn_db takes its new level.
module btn_debounce
    import btn_charge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          btn_s;
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit = (btn_s != btn_db) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1  <= 1'b0;
            btn_s  <= 1'b0;
            btn_db <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            rise  <= hit & btn_s;
            fall  <= hit & ~btn_s;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                btn_db <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_charge.sv
// Press-duration jump charger feeding the game fsm over valid/ready.
// Define BTN_CHARGE_AUTO_RELEASE_EN to auto-offer when the charge saturates.
module btn_charge #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHARGE_W        = btn_charge_pkg::CHARGE_W,
    parameter int CHARGE_MAX      = btn_charge_pkg::CHARGE_MAX,
    parameter int CHARGE_MIN      = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                btn_raw,
    input  logic                rtick,
    input  logic                jump_ready,
    output logic                jump_valid,
    output logic [CHARGE_W-1:0] jump_power,
    output logic                charging,
    output logic [CHARGE_W-1:0] charge_level
);

    import btn_charge_pkg::*;

    localparam logic [CHARGE_W-1:0] LVL_MAX = CHARGE_W'(CHARGE_MAX);
    localparam logic [CHARGE_W-1:0] LVL_MIN = CHARGE_W'(CHARGE_MIN);

    charge_state_t       state;
    charge_state_t       state_n;
    logic                btn_db;
    logic                rise;
    logic                fall;
    logic                latch;
    logic [CHARGE_W-1:0] lvl_inc;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk    (clk),
        .clr    (clr),
        .btn_raw(btn_raw),
        .btn_db (btn_db),
        .rise   (rise),
        .fall   (fall)
    );

    // Increment is applied before a same-cycle fall is evaluated
    assign lvl_inc = (rtick && charge_level != LVL_MAX)
                   ? charge_level + 1'b1 : charge_level;
    assign latch   = (state == CHARGE) && (state_n == OFFER);

`ifdef BTN_CHARGE_AUTO_RELEASE_EN
    // Button still down after an auto offer: hold off until it is released
    logic held;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            held <= 1'b0;
        end else if (latch) begin
            held <= !fall;
        end else if (fall) begin
            held <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = jump_ready ? CHARGE : LOCKOUT;
                end
            end
            CHARGE: begin
                if (fall) begin
                    state_n = (lvl_inc >= LVL_MIN) ? OFFER : IDLE;
                end
`ifdef BTN_CHARGE_AUTO_RELEASE_EN
                else if (rtick && lvl_inc == LVL_MAX) begin
                    state_n = OFFER;
                end
`endif
            end
            OFFER: begin
                if (jump_ready) begin
`ifdef BTN_CHARGE_AUTO_RELEASE_EN
                    state_n = (held && !fall) ? LOCKOUT : IDLE;
`else
                    state_n = IDLE;
`endif
                end
            end
            LOCKOUT: begin
                if (fall) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        charging   = (state == CHARGE);
        jump_valid = (state == OFFER);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            charge_level <= '0;
            jump_power   <= '0;
        end else begin
            charge_level <= (state == CHARGE && state_n == CHARGE)
                          ? lvl_inc : '0;
            if (latch) begin
                jump_power <= lvl_inc;
            end
        end
    end

endmodule

// File: tb/tb_btn_charge.sv
// Directed self-checking bench for btn_charge with DEBOUNCE_CYCLES=8.
// Expected values are hand-derived from the debounce latency and charge rules.
module tb_btn_charge;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_raw;
    logic       rtick;
    logic       jump_ready;
    logic       jump_valid;
    logic [7:0] jump_power;
    logic       charging;
    logic [7:0] charge_level;

    int errors = 0;
    int checks = 0;
    int rise_cnt = 0;
    int offers = 0;
    logic jv_prev = 1'b0;
    int offers_snap;

    btn_charge #(
        .DEBOUNCE_CYCLES(8),
        .CHARGE_W       (8),
        .CHARGE_MAX     (200),
        .CHARGE_MIN     (4)
    ) u_dut (
        .clk         (clk),
        .clr         (clr),
        .btn_raw     (btn_raw),
        .rtick       (rtick),
        .jump_ready  (jump_ready),
        .jump_valid  (jump_valid),
        .jump_power  (jump_power),
        .charging    (charging),
        .charge_level(charge_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u_dut.rise === 1'b1) rise_cnt++;
        if (jump_valid === 1'b1 && jv_prev !== 1'b1) offers++;
        jv_prev = jump_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rt(input int n);
        repeat (n) begin
            rtick = 1'b1;
            tick(1);
            rtick = 1'b0;
            tick(1);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_charging(input string tag);
        int k = 0;
        while (charging !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(charging), 1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (jump_valid !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(jump_valid), 1);
    endtask

    initial begin
        clr        = 1'b0;
        btn_raw    = 1'b0;
        rtick      = 1'b0;
        jump_ready = 1'b0;
        tick(3);
        chk("rst_valid", 32'(jump_valid), 0);
        chk("rst_charging", 32'(charging), 0);
        chk("rst_level", 32'(charge_level), 0);
        chk("rst_power", 32'(jump_power), 0);
        clr = 1'b1;
        tick(2);

        // bounce: five toggles 3 clk apart, ending high
        jump_ready = 1'b1;
        rise_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn_raw = ~btn_raw;
            if (i < 4) tick(3);
        end
        tick(9);
        chk("db_before", 32'(u_dut.u_db.btn_db), 0);
        tick(1);
        chk("db_at_10", 32'(u_dut.u_db.btn_db), 1);
        tick(1);
        chk("charge_start", 32'(charging), 1);
        tick(20);
        chk("one_rise", 32'(rise_cnt), 1);

        // normal jump
        jump_ready = 1'b0;
        rt(37);
        chk("level_37", 32'(charge_level), 37);
        btn_raw = 1'b0;
        wait_valid("norm_valid");
        chk("norm_power", 32'(jump_power), 37);
        chk("norm_level0", 32'(charge_level), 0);
        chk("norm_notchg", 32'(charging), 0);
        tick(20);
        chk("hold_valid", 32'(jump_valid), 1);
        chk("hold_power", 32'(jump_power), 37);
        jump_ready = 1'b1;
        tick(1);
        chk("hs_drop", 32'(jump_valid), 0);
        chk("hs_keep_power", 32'(jump_power), 37);
        chk("hs_idle", 32'(u_dut.state), 0);

        // tap shorter than CHARGE_MIN
        offers_snap = offers;
        btn_raw = 1'b1;
        wait_charging("tap_chg");
        rt(3);
        btn_raw = 1'b0;
        tick(15);
        chk("tap_novalid", 32'(jump_valid), 0);
        chk("tap_nooffer", 32'(offers), 32'(offers_snap));
        chk("tap_idle", 32'(u_dut.state), 0);

        // saturation
        btn_raw = 1'b1;
        wait_charging("sat_chg");
        jump_ready = 1'b0;
`ifdef BTN_CHARGE_AUTO_RELEASE_EN
        offers_snap = offers;
        rt(199);
        chk("auto_199", 32'(charge_level), 199);
        chk("auto_not_yet", 32'(jump_valid), 0);
        rt(1);
        chk("auto_valid", 32'(jump_valid), 1);
        chk("auto_power", 32'(jump_power), 200);
        rt(20);
        jump_ready = 1'b1;
        tick(1);
        chk("auto_drop", 32'(jump_valid), 0);
        chk("auto_lockout", 32'(u_dut.state), 3);
        rt(10);
        chk("auto_one_offer", 32'(offers), 32'(offers_snap + 1));
        btn_raw = 1'b0;
        tick(15);
        chk("auto_idle", 32'(u_dut.state), 0);
`else
        rt(300);
        chk("sat_level", 32'(charge_level), 200);
        chk("sat_still", 32'(charging), 1);
        btn_raw = 1'b0;
        wait_valid("sat_valid");
        chk("sat_power", 32'(jump_power), 200);
        jump_ready = 1'b1;
        tick(1);
        chk("sat_drop", 32'(jump_valid), 0);
`endif

        // busy lockout
        jump_ready = 1'b0;
        offers_snap = offers;
        btn_raw = 1'b1;
        tick(12);
        chk("busy_lockout", 32'(u_dut.state), 3);
        jump_ready = 1'b1;
        rt(5);
        chk("busy_nochg", 32'(charging), 0);
        chk("busy_level", 32'(charge_level), 0);
        btn_raw = 1'b0;
        tick(15);
        chk("busy_idle", 32'(u_dut.state), 0);
        chk("busy_nooffer", 32'(offers), 32'(offers_snap));

        // reset mid-charge
        btn_raw = 1'b1;
        wait_charging("rst_chg");
        rt(50);
        chk("rst_lvl50", 32'(charge_level), 50);
        clr = 1'b0;
        #1;
        chk("rst_async_chg", 32'(charging), 0);
        chk("rst_async_lvl", 32'(charge_level), 0);
        chk("rst_async_pwr", 32'(jump_power), 0);
        chk("rst_async_val", 32'(jump_valid), 0);
        tick(3);
        clr = 1'b1;
        offers_snap = offers;
        tick(5);
        chk("post_rst_chg", 32'(charging), 0);
        chk("post_rst_val", 32'(jump_valid), 0);
        wait_charging("fresh_chg");
        chk("fresh_lvl0", 32'(charge_level), 0);
        btn_raw = 1'b0;
        tick(15);
        chk("fresh_nooffer", 32'(offers), 32'(offers_snap));
        chk("fresh_idle", 32'(u_dut.state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
